// File: rtl/conv3x3_engine.sv
// conv3x3_engine: 3x3 shift-weighted convolution that reads an SRAM image and writes results sequentially.
// Optional build macro CONV3X3_BORDER_EN: process the full frame with edge-clamped taps.
module conv3x3_engine #(
  parameter int IMG_W    = 512,
  parameter int IMG_H    = 512,
  parameter int PIX_W    = 16,
  parameter int ADDR_W   = 19,
  parameter int SRC_BASE = 0,
  parameter int DST_BASE = 262144,
  parameter int ACC_W    = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [PIX_W-1:0]  mem_wdata,
  input  logic [PIX_W-1:0]  mem_rdata,
  output logic [ACC_W-1:0]  result,
  output logic              o_en,
  output logic [1:0]        dbg_state_o
);
  // Handshake: start is a one-cycle request honoured only in IDLE; busy covers RD/WR;
  // done pulses for one cycle with busy already low; o_en qualifies result for one cycle.
  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2, FIN = 2'd3} state_t;

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
`ifdef CONV3X3_BORDER_EN
  localparam logic [XW-1:0] X_FIRST = '0;
  localparam logic [XW-1:0] X_LAST  = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_FIRST = '0;
  localparam logic [YW-1:0] Y_LAST  = YW'(IMG_H - 1);
`else
  localparam logic [XW-1:0] X_FIRST = XW'(1);
  localparam logic [XW-1:0] X_LAST  = XW'(IMG_W - 2);
  localparam logic [YW-1:0] Y_FIRST = YW'(1);
  localparam logic [YW-1:0] Y_LAST  = YW'(IMG_H - 2);
`endif

  state_t             state_q;
  logic [XW-1:0]      x_q;
  logic [YW-1:0]      y_q;
  logic [3:0]         t_q;
  logic [ACC_W-1:0]   acc_q;
  logic [ADDR_W-1:0]  wptr_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [ACC_W-1:0]   result_q;
  logic               copy_q;
  logic               busy_q;
  logic               done_q;
  logic               rd_q;
  logic               wr_q;
  logic               oen_q;

  logic [ACC_W-1:0]   sum_d;
  logic [XW-1:0]      x_d;
  logic [YW-1:0]      y_d;
  logic               last_px;

  // Tap t covers (dy,dx) = (t/3-1, t%3-1) around the current output pixel.
  function automatic logic [ADDR_W-1:0] tap_addr(input logic [XW-1:0] px,
                                                 input logic [YW-1:0] py,
                                                 input logic [3:0]    t);
    int tx;
    int ty;
    tx = int'(px) + int'(t) % 3 - 1;
    ty = int'(py) + int'(t) / 3 - 1;
`ifdef CONV3X3_BORDER_EN
    if (tx < 0) tx = 0;
    else if (tx > IMG_W - 1) tx = IMG_W - 1;
    if (ty < 0) ty = 0;
    else if (ty > IMG_H - 1) ty = IMG_H - 1;
`endif
    return ADDR_W'(SRC_BASE + ty * IMG_W + tx);
  endfunction

  function automatic logic [ACC_W-1:0] weigh(input logic [PIX_W-1:0] d,
                                             input logic [3:0]       t,
                                             input logic             cp);
    logic [ACC_W-1:0] dz;
    logic [ACC_W-1:0] w;
    dz = {{(ACC_W-PIX_W){1'b0}}, d};
    if (cp) begin
      w = (t == 4'd4) ? dz : '0;
    end else begin
      case (t)
        4'd4:                   w = dz >> 2;
        4'd1, 4'd3, 4'd5, 4'd7: w = dz >> 3;
        default:                w = dz >> 4;
      endcase
    end
    return w;
  endfunction

  always_comb begin
    sum_d   = acc_q + weigh(mem_rdata, 4'd8, copy_q);
    last_px = (x_q == X_LAST) && (y_q == Y_LAST);
    x_d     = x_q + XW'(1);
    y_d     = y_q;
    if (x_q == X_LAST) begin
      x_d = X_FIRST;
      y_d = y_q + YW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      t_q      <= '0;
      acc_q    <= '0;
      wptr_q   <= '0;
      addr_q   <= '0;
      result_q <= '0;
      copy_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      oen_q    <= 1'b0;
    end else begin
      oen_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            copy_q  <= (mode == 2'd1);
            x_q     <= X_FIRST;
            y_q     <= Y_FIRST;
            t_q     <= '0;
            wptr_q  <= ADDR_W'(DST_BASE);
            busy_q  <= 1'b1;
            rd_q    <= 1'b1;
            addr_q  <= tap_addr(X_FIRST, Y_FIRST, 4'd0);
            state_q <= RD;
          end
        end
        RD: begin
          // Read data lags the strobe by one cycle, so this cycle carries tap t-1.
          acc_q <= (t_q == 4'd0) ? '0 : acc_q + weigh(mem_rdata, t_q - 4'd1, copy_q);
          if (t_q == 4'd8) begin
            rd_q    <= 1'b0;
            wr_q    <= 1'b1;
            addr_q  <= wptr_q;
            state_q <= WR;
          end else begin
            t_q    <= t_q + 4'd1;
            addr_q <= tap_addr(x_q, y_q, t_q + 4'd1);
          end
        end
        WR: begin
          wr_q     <= 1'b0;
          result_q <= sum_d;
          oen_q    <= 1'b1;
          wptr_q   <= wptr_q + ADDR_W'(1);
          t_q      <= '0;
          if (last_px) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= FIN;
          end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            rd_q    <= 1'b1;
            addr_q  <= tap_addr(x_d, y_d, 4'd0);
            state_q <= RD;
          end
        end
        FIN: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Write data carries the tap-8 sum straight through in the WR cycle.
  assign mem_wdata   = (state_q == WR) ? sum_d[PIX_W-1:0] : '0;
  assign mem_addr    = addr_q;
  assign mem_rd      = rd_q;
  assign mem_wr      = wr_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign result      = result_q;
  assign o_en        = oen_q;
  assign dbg_state_o = state_q;
endmodule

// File: tb/tb_conv3x3_engine.sv
// Self-checking bench for conv3x3_engine on a 4x4 image against a pixel-level reference model.
module tb_conv3x3_engine;
  localparam int IMG_W    = 4;
  localparam int IMG_H    = 4;
  localparam int PIX_W    = 16;
  localparam int ADDR_W   = 8;
  localparam int SRC_BASE = 8;
  localparam int DST_BASE = 100;
  localparam int ACC_W    = 20;
`ifdef CONV3X3_BORDER_EN
  localparam int X0 = 0, X1 = IMG_W - 1, Y0 = 0, Y1 = IMG_H - 1;
`else
  localparam int X0 = 1, X1 = IMG_W - 2, Y0 = 1, Y1 = IMG_H - 2;
`endif
  localparam int NPIX = (X1 - X0 + 1) * (Y1 - Y0 + 1);
  localparam int CYC_PER_PIX = 10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              start;
  logic [1:0]        mode;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_wr;
  logic [PIX_W-1:0]  mem_wdata;
  logic [PIX_W-1:0]  mem_rdata;
  logic [ACC_W-1:0]  result;
  logic              o_en;
  logic [1:0]        dbg_state;

  conv3x3_engine #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .PIX_W(PIX_W), .ADDR_W(ADDR_W),
    .SRC_BASE(SRC_BASE), .DST_BASE(DST_BASE), .ACC_W(ACC_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .busy(busy), .done(done),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .result(result), .o_en(o_en), .dbg_state_o(dbg_state)
  );

  // ---------------- SRAM model (source region only; writes are logged) ----------------
  int src_img [IMG_W*IMG_H];
  logic [PIX_W-1:0] rdata_q = '0;
  assign mem_rdata = rdata_q;

  function automatic logic [PIX_W-1:0] src_word(input logic [ADDR_W-1:0] a);
    int i;
    i = int'(a) - SRC_BASE;
    if (i >= 0 && i < IMG_W * IMG_H) return PIX_W'(src_img[i]);
    return 16'hDEAD;
  endfunction

  always @(posedge clk) begin
    if (mem_rd) rdata_q <= src_word(mem_addr);
  end

  // ---------------- scoreboard ----------------
  logic [ACC_W-1:0]  exp_q[$];
  logic [ADDR_W-1:0] obs_addr_q[$];
  logic [PIX_W-1:0]  obs_data_q[$];
  logic [ACC_W-1:0]  obs_res_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int cyc;
  int overlap_cnt;
  int rd_cnt;
  logic rd_seen;
  logic [ADDR_W-1:0] first_rd;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: each tap contributes pixel >> (2 + |dx| + |dy|); copy keeps only the centre.
  function automatic int ref_pix(input int x, input int y, input bit cp);
    int s;
    int xx;
    int yy;
    int p;
    s = 0;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        xx = x + dx;
        yy = y + dy;
`ifdef CONV3X3_BORDER_EN
        if (xx < 0) xx = 0;
        if (xx > IMG_W - 1) xx = IMG_W - 1;
        if (yy < 0) yy = 0;
        if (yy > IMG_H - 1) yy = IMG_H - 1;
`endif
        p = src_img[yy * IMG_W + xx];
        if (cp) begin
          if (dx == 0 && dy == 0) s += p;
        end else begin
          s += p >> (2 + int'(dx != 0) + int'(dy != 0));
        end
      end
    end
    return s;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (mem_wr) begin
      obs_addr_q.push_back(mem_addr);
      obs_data_q.push_back(mem_wdata);
    end
    if (o_en) obs_res_q.push_back(result);
    if (mem_rd && mem_wr) overlap_cnt++;
    if (mem_rd) rd_cnt++;
    if (mem_rd && !rd_seen) begin
      first_rd = mem_addr;
      rd_seen  = 1'b1;
    end
  endtask

  task automatic clear_obs();
    obs_addr_q.delete();
    obs_data_q.delete();
    obs_res_q.delete();
    overlap_cnt = 0;
    rd_cnt      = 0;
    rd_seen     = 1'b0;
    cyc         = 0;
  endtask

  task automatic load_image(input int kind);
    for (int i = 0; i < IMG_W * IMG_H; i++) begin
      case (kind)
        0:       src_img[i] = 16;
        1:       src_img[i] = i;
        2:       src_img[i] = 16'hFFFF;
        default: src_img[i] = int'($urandom_range(0, 16'hFFFF));
      endcase
    end
  endtask

  task automatic run_frame(input string name, input logic [1:0] md, input bit disturb);
    int busy_cyc;
    int done_cyc;
    bit cp;
    cp = (md == 2'd1);
    exp_q.delete();
    for (int y = Y0; y <= Y1; y++)
      for (int x = X0; x <= X1; x++)
        exp_q.push_back(ACC_W'(ref_pix(x, y, cp)));
    clear_obs();
    busy_cyc = -1;
    done_cyc = -1;
    mode  = md;
    start = 1'b1;
    tick();
    start = 1'b0;
    if (busy) busy_cyc = cyc;
    while (done_cyc < 0 && cyc < NPIX * CYC_PER_PIX + 40) begin
      if (disturb && cyc == 5)  begin start = 1'b1; mode = ~md; end
      if (disturb && cyc == 6)  start = 1'b0;
      if (disturb && cyc == 23) begin start = 1'b1; mode = 2'd3 - md; end
      if (disturb && cyc == 24) start = 1'b0;
      tick();
      if (busy && busy_cyc < 0) busy_cyc = cyc;
      if (done) done_cyc = cyc;
    end
    check_eq({name, ":done_seen"}, 32'(done_cyc >= 0), 1);
    check_eq({name, ":busy_rise"}, busy_cyc, 1);
    check_eq({name, ":done_latency"}, done_cyc - busy_cyc, NPIX * CYC_PER_PIX);
    check_eq({name, ":busy_at_done"}, 32'(busy), 0);
    if (disturb) start = 1'b1;
    tick();
    start = 1'b0;
    check_eq({name, ":done_width"}, 32'(done), 0);
    check_eq({name, ":idle_after"}, 32'(busy), 0);
    tick();
    tick();
    check_eq({name, ":n_writes"}, obs_addr_q.size(), NPIX);
    check_eq({name, ":n_oen"}, obs_res_q.size(), NPIX);
    for (int i = 0; i < NPIX; i++) begin
      if (i < obs_addr_q.size()) begin
        check_eq({name, ":wr_addr"}, 32'(obs_addr_q[i]), DST_BASE + i);
        check_eq({name, ":wr_data"}, 32'(obs_data_q[i]), 32'(exp_q[i][PIX_W-1:0]));
      end
      if (i < obs_res_q.size())
        check_eq({name, ":result"}, 32'(obs_res_q[i]), 32'(exp_q[i]));
    end
    check_eq({name, ":result_held"}, 32'(result), 32'(exp_q[NPIX-1]));
    check_eq({name, ":rd_wr_overlap"}, overlap_cnt, 0);
    check_eq({name, ":n_reads"}, rd_cnt, NPIX * 9);
    check_eq({name, ":first_rd"}, 32'(first_rd), SRC_BASE);
  endtask

  task automatic run_reset_abort();
    clear_obs();
    mode  = 2'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (cyc < 14) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("abort:busy", 32'(busy), 0);
    check_eq("abort:mem_wr", 32'(mem_wr), 0);
    check_eq("abort:mem_rd", 32'(mem_rd), 0);
    check_eq("abort:o_en", 32'(o_en), 0);
    check_eq("abort:result", 32'(result), 0);
    check_eq("abort:pre_writes", obs_addr_q.size(), 1);
    rd_cnt = 0;
    repeat (30) tick();
    check_eq("abort:post_writes", obs_addr_q.size(), 1);
    check_eq("abort:post_reads", rd_cnt, 0);
    check_eq("abort:still_idle", 32'(busy), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst   = 1'b1;
    start = 1'b0;
    mode  = 2'd0;
    load_image(0);
    clear_obs();
    repeat (3) tick();
    check_eq("reset:busy", 32'(busy), 0);
    check_eq("reset:done", 32'(done), 0);
    check_eq("reset:mem_rd", 32'(mem_rd), 0);
    check_eq("reset:mem_wr", 32'(mem_wr), 0);
    check_eq("reset:o_en", 32'(o_en), 0);
    check_eq("reset:result", 32'(result), 0);
    check_eq("reset:mem_addr", 32'(mem_addr), 0);
    check_eq("reset:mem_wdata", 32'(mem_wdata), 0);
    rst = 1'b0;
    tick();

    load_image(0);
    run_frame("const16", 2'd0, 1'b0);
    load_image(1);
    run_frame("ramp_copy", 2'd1, 1'b0);
    load_image(2);
    run_frame("all_ones", 2'd0, 1'b0);

    load_image(0);
    run_reset_abort();
    run_frame("after_abort", 2'd0, 1'b0);

    load_image(3);
    run_frame("disturb_gauss", 2'd0, 1'b1);
    load_image(3);
    run_frame("disturb_copy", 2'd1, 1'b1);

    for (int k = 0; k < 6; k++) begin
      load_image(3);
      run_frame($sformatf("rand%0d", k), 2'($urandom_range(0, 3)), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/conv3x3_engine.md
Name: conv3x3_engine

Overview:
- Parametrised 3x3 shift-weighted convolution engine; successor to the fixed 512x512 Gaussian blur sequencer.
- Reads source pixels from single-port SRAM, accumulates 9 taps per output pixel, writes results sequentially to a destination region, and streams each result on a valid-qualified output.
- Adds parametrised image geometry, pixel width and SRAM map, a start/busy/done handshake, and a mode select.

Parameters:
IMG_W, 512, image width in pixels (>=3)
IMG_H, 512, image height in pixels (>=3)
PIX_W, 16, pixel / SRAM data width
ADDR_W, 19, SRAM address width
SRC_BASE, 0, word address of source pixel (0,0); row-major, stride IMG_W
DST_BASE, 262144, word address of first output pixel
ACC_W, 20, accumulator and result width (>=PIX_W+2)

Ports:
clk  input  1  clock
rst  input  1  reset
start  input  1  one-cycle start pulse, sampled in IDLE only
mode  input  2  0=Gaussian, 1=copy, 2/3 treated as 0; sampled on accepted start
busy  output  1  high from the cycle after start until done
done  output  1  one-cycle pulse after the final write
mem_addr  output  ADDR_W  SRAM address
mem_rd  output  1  read strobe; data returned on mem_rdata next cycle
mem_wr  output  1  write strobe
mem_wdata  output  PIX_W  write data
mem_rdata  input  PIX_W  read data, 1-cycle latency
result  output  ACC_W  last computed pixel, held between updates
o_en  output  1  one-cycle pulse, result valid

Behaviour:
- Reset: synchronous, active-high, on posedge clk.
  - State -> IDLE.
  - busy, done, mem_rd, mem_wr, o_en = 0.
  - result, mem_wdata, mem_addr = 0.
  - x, y, tap and write-pointer counters cleared.
  - Reset mid-frame aborts immediately; no further reads or writes.
- States: IDLE -> RD -> WR -> (RD | FIN) -> IDLE.
- IDLE:
  - start=1 latches mode, sets x=1, y=1, wptr=DST_BASE, goes to RD.
  - start in any other state is ignored.
- RD: tap counter t = 0..8, one read per cycle, mem_rd=1.
  - Tap (dy,dx) = (t/3-1, t%3-1).
  - mem_addr = SRC_BASE + (y+dy)*IMG_W + (x+dx), truncated to ADDR_W.
  - Data for tap t arrives in cycle t+1 and is added to acc. acc clears at t=0.
- Tap weights (right shifts, zero-extended to ACC_W):
  - Gaussian: corners >>4, edges >>3, centre >>2. Sum of weights is 1, so the total never exceeds 2^PIX_W-1.
  - Copy: centre >>0, all other taps contribute 0.
- WR (1 cycle):
  - Tap 8 data is added combinationally: sum = acc + w8(mem_rdata).
  - mem_wr=1, mem_addr=wptr, mem_wdata=sum[PIX_W-1:0].
  - result<=sum, o_en=1 for this cycle, wptr increments.
- Throughput: 10 cycles per output pixel, fixed.
- Raster order after each WR:
  - x increments.
  - At x=IMG_W-2: x=1 and y increments.
  - After (IMG_W-2, IMG_H-2) the next state is FIN, not RD.
- FIN: done=1 for 1 cycle, busy drops in the same cycle, return to IDLE.
- Without border support, output count is (IMG_W-2)*(IMG_H-2), written contiguously from DST_BASE.
- mem_rd and mem_wr are never high in the same cycle.
- result holds its value until the next WR or reset.

Optional Feature:
- Macro: CONV3X3_BORDER_EN.
- Defined:
  - Full frame is processed: x in 0..IMG_W-1, y in 0..IMG_H-1, starting at (0,0).
  - Out-of-range tap coordinates are clamped to the nearest edge.
  - IMG_W*IMG_H outputs are written from DST_BASE.
- Undefined: interior-only behaviour as above; no clamp logic is synthesised.

Test Plan:
- IMG_W=IMG_H=4, all source pixels 16, mode 0, start -> 4 writes of 16 at DST_BASE..+3, o_en 4 times with result=16, done exactly 40 cycles after busy rises.
- 4x4 ramp source value=y*4+x, mode 1 -> writes 5,6,9,10 in order; result=10 at the final o_en.
- 4x4 all 0xFFFF, PIX_W=16, mode 0 -> each write is 0xFFF7 (0x3FFC+0x7FFC+0x3FFF); no wrap into upper bits.
- rst asserted at cycle 15 of a 4x4 run -> next cycle busy=0, mem_wr=0, no further writes; new start runs the full 40 cycles.
- start pulsed while busy, and mode changed mid-run -> ignored; output sequence identical to the undisturbed run.
- CONV3X3_BORDER_EN, 4x4 constant 16, mode 0 -> 16 writes all =16, done after 160 cycles; first read address=SRC_BASE (clamped (-1,-1)).
